// File: rtl/sr_cmd_gen.sv
// Set/clear command front-end for the SR flip-flop: synchronise, debounce, and emit exclusive s/r pulses.
// Optional macro SR_CMD_RESET_PRIORITY_EN: a simultaneous set+clear in IDLE issues a clear pulse.
module sr_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 2,
    parameter int GUARD_CYCLES    = 2,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_req,
    input  logic       rst_req,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] dropped_cnt
);

    typedef enum logic [1:0] {IDLE, SET_P, RST_P, GUARD} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Channel 0 is set, channel 1 is clear
    logic [1:0]       req;
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       stable;
    logic [1:0]       evt;
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       evt_n;

    assign req   = {rst_req, set_req};
    assign evt_n = {1'b0, evt[0]} + {1'b0, evt[1]};

    // Synchroniser (p0, p1) and debounce stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            stable    <= '0;
            evt       <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_p0 <= req;
            sync_p1 <= sync_p0;
            for (int ch = 0; ch < 2; ch++) begin
                evt[ch] <= 1'b0;
                if (sync_p1[ch] == stable[ch]) begin
                    db_cnt[ch] <= '0;
                end else if (db_cnt[ch] == DB_LAST) begin
                    db_cnt[ch] <= '0;
                    stable[ch] <= sync_p1[ch];
                    evt[ch]    <= sync_p1[ch];
                end else begin
                    db_cnt[ch] <= db_cnt[ch] + 1'b1;
                end
            end
        end
    end

    state_t           state;
    logic [CNT_W-1:0] fsm_cnt;

    // Command FSM stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fsm_cnt     <= '0;
            s           <= 1'b0;
            r           <= 1'b0;
            busy        <= 1'b0;
            conflict    <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    fsm_cnt <= '0;
                    if (evt[0] && evt[1]) begin
                        conflict <= 1'b1;
`ifdef SR_CMD_RESET_PRIORITY_EN
                        state       <= RST_P;
                        r           <= 1'b1;
                        busy        <= 1'b1;
                        dropped_cnt <= sat_add(dropped_cnt, 2'd1);
`else
                        state <= IDLE;
`endif
                    end else if (evt[0]) begin
                        state <= SET_P;
                        s     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (evt[1]) begin
                        state <= RST_P;
                        r     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SET_P, RST_P: begin
                    dropped_cnt <= sat_add(dropped_cnt, evt_n);
                    if (fsm_cnt == PW_LAST) begin
                        s       <= 1'b0;
                        r       <= 1'b0;
                        fsm_cnt <= '0;
                        if (GUARD_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GUARD;
                        end
                    end else begin
                        fsm_cnt <= fsm_cnt + 1'b1;
                    end
                end
                GUARD: begin
                    dropped_cnt <= sat_add(dropped_cnt, evt_n);
                    if (fsm_cnt == GD_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        fsm_cnt <= '0;
                    end else begin
                        fsm_cnt <= fsm_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    s     <= 1'b0;
                    r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
